// File: rtl/l2_fill_arbiter_if.sv
// ============================================================================
// Module  : l2_fill_arbiter_if
// Brief   : Bundles the IC/DC miss handshakes and the L2 stub port for the fill arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface l2_fill_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_gnt;
    logic              ic_done;
    logic              dc_req;
    logic [ADDR_W-1:0] dc_addr;
    logic              dc_wr;
    logic              dc_gnt;
    logic              dc_done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem_ready;
    logic              err;

    // Arbiter side.
    modport master (
        input  ic_req, ic_addr, dc_req, dc_addr, dc_wr, mem_ready,
        output ic_gnt, ic_done, dc_gnt, dc_done, mem_addr, mem_rd, mem_wr, err
    );

    // Caches and stub side.
    modport slave (
        output ic_req, ic_addr, dc_req, dc_addr, dc_wr, mem_ready,
        input  ic_gnt, ic_done, dc_gnt, dc_done, mem_addr, mem_rd, mem_wr, err
    );
endinterface

`default_nettype wire

// File: rtl/l2_fill_arbiter.sv
// ============================================================================
// Module  : l2_fill_arbiter
// Brief   : Round-robin arbiter sharing the L2 stub port between IC and DC line
//           traffic, with per-transaction timeout. Optional counters: ARB_STATS_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module l2_fill_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 64,
    parameter int TIMEOUT    = 255,
    parameter int CNT_W      = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    l2_fill_arbiter_if.master bus
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]       ic_grants,
    output logic [31:0]       dc_grants,
    output logic [15:0]       timeouts
`endif
);

    localparam int             c_OFF_W   = $clog2(LINE_BYTES);
    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_BUSY = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic              r_owner_dc;
    logic              r_last_dc;
    logic              r_wr;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_pick_dc;
    logic              w_any_req;
    logic [ADDR_W-1:0] w_req_addr;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_busy;
    logic              w_done;

    // On a tie the requester that was not served last wins.
    assign w_any_req  = bus.ic_req | bus.dc_req;
    assign w_pick_dc  = bus.dc_req & (~bus.ic_req | ~r_last_dc);
    assign w_req_addr = w_pick_dc ? bus.dc_addr : bus.ic_addr;
    // Counter holds the number of BUSY cycles already elapsed, so the
    // transaction aborts at the end of its TIMEOUT-th BUSY cycle.
    assign w_cnt_nxt  = r_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_S_IDLE;
            r_owner_dc <= 1'b0;
            r_last_dc  <= 1'b1;
            r_wr       <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_any_req) begin
                        r_owner_dc <= w_pick_dc;
                        r_addr     <= {w_req_addr[ADDR_W-1:c_OFF_W], {c_OFF_W{1'b0}}};
                        r_wr       <= w_pick_dc & bus.dc_wr;
                        r_err      <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= c_S_BUSY;
                    end
                end
                c_S_BUSY: begin
                    r_cnt <= w_cnt_nxt;
                    if (bus.mem_ready) begin
                        r_err   <= 1'b0;
                        r_state <= c_S_DONE;
                    end else if (w_cnt_nxt == c_TIMEOUT) begin
                        r_err   <= 1'b1;
                        r_state <= c_S_DONE;
                    end
                end
                c_S_DONE: begin
                    r_last_dc <= r_owner_dc;
                    r_cnt     <= '0;
                    r_state   <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign w_busy = (r_state == c_S_BUSY);
    assign w_done = (r_state == c_S_DONE);

    assign bus.ic_gnt   = w_busy & ~r_owner_dc;
    assign bus.dc_gnt   = w_busy &  r_owner_dc;
    assign bus.ic_done  = w_done & ~r_owner_dc;
    assign bus.dc_done  = w_done &  r_owner_dc;
    assign bus.mem_rd   = w_busy & ~r_wr;
    assign bus.mem_wr   = w_busy &  r_wr;
    assign bus.err      = w_done &  r_err;
    assign bus.mem_addr = r_addr;

`ifdef ARB_STATS_EN
    logic [31:0] r_ic_grants;
    logic [31:0] r_dc_grants;
    logic [15:0] r_timeouts;

    // Event counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ic_grants <= '0;
            r_dc_grants <= '0;
            r_timeouts  <= '0;
        end else if (w_done) begin
            if (!r_owner_dc && (r_ic_grants != '1)) begin
                r_ic_grants <= r_ic_grants + 32'd1;
            end
            if (r_owner_dc && (r_dc_grants != '1)) begin
                r_dc_grants <= r_dc_grants + 32'd1;
            end
            if (r_err && (r_timeouts != '1)) begin
                r_timeouts <= r_timeouts + 16'd1;
            end
        end
    end

    assign ic_grants = r_ic_grants;
    assign dc_grants = r_dc_grants;
    assign timeouts  = r_timeouts;
`endif

endmodule

`default_nettype wire

// File: tb/tb_l2_fill_arbiter.sv
// ============================================================================
// Module  : tb_l2_fill_arbiter
// Brief   : Directed self-checking bench for l2_fill_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_l2_fill_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l2_fill_arbiter_if #(.ADDR_W(32)) bus ();

`ifdef ARB_STATS_EN
    logic [31:0] ic_grants;
    logic [31:0] dc_grants;
    logic [15:0] timeouts;
`endif

    l2_fill_arbiter #(
        .ADDR_W    (32),
        .LINE_BYTES(64),
        .TIMEOUT   (255),
        .CNT_W     (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ARB_STATS_EN
        ,
        .ic_grants(ic_grants),
        .dc_grants(dc_grants),
        .timeouts (timeouts)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {ic_gnt, ic_done, dc_gnt, dc_done, mem_rd, mem_wr, err}
    function automatic logic [6:0] outs();
        return {bus.ic_gnt, bus.ic_done, bus.dc_gnt, bus.dc_done,
                bus.mem_rd, bus.mem_wr, bus.err};
    endfunction

    localparam logic [6:0] O_IDLE    = 7'h00;
    localparam logic [6:0] O_IC_RD   = 7'h44;
    localparam logic [6:0] O_IC_DONE = 7'h20;
    localparam logic [6:0] O_DC_WR   = 7'h12;
    localparam logic [6:0] O_DC_RD   = 7'h14;
    localparam logic [6:0] O_DC_DONE = 7'h08;
    localparam logic [6:0] O_DC_TOUT = 7'h09;

    initial begin
        int n_rd;
        bus.ic_req    = 1'b0;
        bus.ic_addr   = '0;
        bus.dc_req    = 1'b0;
        bus.dc_addr   = '0;
        bus.dc_wr     = 1'b0;
        bus.mem_ready = 1'b0;
        rst           = 1'b1;
        tick();
        tick();
        check("reset outs", 32'(outs()), 32'(O_IDLE));
        check("reset mem_addr", bus.mem_addr, 32'h0);
        rst = 1'b0;

        // IC only, ready on the 3rd BUSY cycle
        bus.ic_req  = 1'b1;
        bus.ic_addr = 32'h0000_1234;
        tick();
        check("t1 busy1 outs", 32'(outs()), 32'(O_IC_RD));
        check("t1 mem_addr", bus.mem_addr, 32'h0000_1200);
        bus.ic_addr = 32'hFFFF_FFFF;
        tick();
        check("t1 busy2 outs", 32'(outs()), 32'(O_IC_RD));
        check("t1 addr held", bus.mem_addr, 32'h0000_1200);
        tick();
        check("t1 busy3 outs", 32'(outs()), 32'(O_IC_RD));
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        bus.ic_req    = 1'b0;
        check("t1 done outs", 32'(outs()), 32'(O_IC_DONE));
        tick();
        check("t1 idle outs", 32'(outs()), 32'(O_IDLE));

        // reset on 2nd BUSY cycle of a DC writeback
        bus.dc_req  = 1'b1;
        bus.dc_wr   = 1'b1;
        bus.dc_addr = 32'h0000_2000;
        tick();
        check("t5 busy1 outs", 32'(outs()), 32'(O_DC_WR));
        tick();
        check("t5 busy2 outs", 32'(outs()), 32'(O_DC_WR));
        rst = 1'b1;
        tick();
        check("t5 rst outs", 32'(outs()), 32'(O_IDLE));
        check("t5 rst mem_addr", bus.mem_addr, 32'h0);
        rst        = 1'b0;
        bus.dc_req = 1'b0;
        tick();
        check("t5 no done", 32'(outs()), 32'(O_IDLE));
`ifdef ARB_STATS_EN
        check("t5 ic_grants clr", ic_grants, 32'd0);
        check("t5 dc_grants clr", dc_grants, 32'd0);
        check("t5 timeouts clr", 32'(timeouts), 32'd0);
`endif
        bus.ic_req  = 1'b1;
        bus.ic_addr = 32'h0000_03FF;
        tick();
        check("t5 new busy outs", 32'(outs()), 32'(O_IC_RD));
        check("t5 new mem_addr", bus.mem_addr, 32'h0000_03C0);
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        bus.ic_req    = 1'b0;
        check("t5 new done", 32'(outs()), 32'(O_IC_DONE));
        tick();

        // simultaneous requests after reset, then alternation
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        bus.ic_req  = 1'b1;
        bus.ic_addr = 32'h0000_0040;
        bus.dc_req  = 1'b1;
        bus.dc_addr = 32'h0000_ABCD;
        bus.dc_wr   = 1'b1;
        tick();
        check("t2 ic first", 32'(outs()), 32'(O_IC_RD));
        check("t2 ic mem_addr", bus.mem_addr, 32'h0000_0040);
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        check("t2 ic done", 32'(outs()), 32'(O_IC_DONE));
        tick();
        check("t2 idle1", 32'(outs()), 32'(O_IDLE));
        tick();
        check("t2 dc second", 32'(outs()), 32'(O_DC_WR));
        check("t2 dc mem_addr", bus.mem_addr, 32'h0000_ABC0);
        bus.dc_wr     = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        check("t2 dc done", 32'(outs()), 32'(O_DC_DONE));
        tick();
        check("t2 idle2", 32'(outs()), 32'(O_IDLE));
        tick();
        check("t2 ic third", 32'(outs()), 32'(O_IC_RD));
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        bus.ic_req    = 1'b0;
        bus.dc_req    = 1'b0;
        check("t2 ic done2", 32'(outs()), 32'(O_IC_DONE));
        tick();

        // DC fill, stub never ready
        bus.dc_req  = 1'b1;
        bus.dc_wr   = 1'b0;
        bus.dc_addr = 32'h0000_0100;
        tick();
        check("t3 busy1 outs", 32'(outs()), 32'(O_DC_RD));
        n_rd = 0;
        for (int i = 0; i < 400; i++) begin
            if (bus.dc_done) break;
            if (bus.mem_rd) n_rd++;
            tick();
        end
        check("t3 rd cycles", n_rd, 32'd255);
        check("t3 done+err", 32'(outs()), 32'(O_DC_TOUT));
        bus.dc_req = 1'b0;
        tick();
        check("t3 idle", 32'(outs()), 32'(O_IDLE));

        // ready on the same cycle the timeout would fire
        bus.ic_req  = 1'b1;
        bus.ic_addr = 32'h0000_0080;
        tick();
        repeat (254) tick();
        check("t4 busy255 outs", 32'(outs()), 32'(O_IC_RD));
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        bus.ic_req    = 1'b0;
        check("t4 done no err", 32'(outs()), 32'(O_IC_DONE));
        tick();
        check("t4 idle", 32'(outs()), 32'(O_IDLE));

`ifdef ARB_STATS_EN
        check("stats ic_grants", ic_grants, 32'd3);
        check("stats dc_grants", dc_grants, 32'd2);
        check("stats timeouts", 32'(timeouts), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
